// File: rtl/niosiie_pio_in_edge_pkg.sv
// Shared constants for the edge-capturing input PIO.
// Register map offsets and edge-mode encodings.
package niosiie_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  localparam logic [1:0] WARM_DONE = 2'd3;

endpackage

// File: rtl/niosiie_pio_in_edge_if.sv
// Avalon-MM slave bundle for the input PIO.
// Master drives strobes, slave returns readdata.
interface niosiie_pio_in_edge_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read_n,
    output write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read_n,
    input  write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/niosiie_sync_edge.sv
// 2-FF synchroniser, delay flop and edge decode.
// Events are suppressed while en is low.
module niosiie_sync_edge
  import niosiie_pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] evt
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      d  <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
      d  <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~d;
  assign fall  = ~s2 & d;

  always_comb begin
    evt = '0;
    if (en) begin
      unique case (1'b1)
        (EDGE_TYPE == EDGE_FALLING): evt = fall;
        (EDGE_TYPE == EDGE_ANY):     evt = rise | fall;
        default:                     evt = rise;
      endcase
    end
  end

endmodule

// File: rtl/niosiie_pio_in_edge.sv
// Input PIO with sticky per-bit edge capture and masked irq.
// Register file, capture logic and irq generation.
module niosiie_pio_in_edge
  import niosiie_pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = EDGE_RISING,
  parameter int IRQ_EN    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  niosiie_pio_in_edge_if.slave  bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  logic [1:0]       warm;
  logic             en;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] clr;
  logic             wr;
  logic             rd;
  logic [31:0]      rd_mux;
  logic             unused_wd;

  assign unused_wd = ^bus.writedata;

  niosiie_sync_edge #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .in_port (in_port),
    .level   (level),
    .evt     (evt)
  );

  // Gate edges until the sync chain holds real samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) warm <= '0;
    else if (warm != WARM_DONE) warm <= warm + 2'd1;
  end

  assign en = (warm == WARM_DONE);
  assign wr = bus.chipselect & ~bus.write_n;
  assign rd = bus.chipselect & ~bus.read_n;

  assign clr = (wr && bus.address == ADDR_EDGECAP) ?
               bus.writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap  <= '0;
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      cap <= (cap & ~clr) | evt;
      if (IRQ_EN != 0 && wr && bus.address == ADDR_IRQMASK)
        mask <= bus.writedata[WIDTH-1:0];
      irq <= (IRQ_EN != 0) && |(cap & mask);
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      (bus.address == ADDR_DATA):    rd_mux[WIDTH-1:0] = level;
      (bus.address == ADDR_IRQMASK): rd_mux[WIDTH-1:0] = mask;
      (bus.address == ADDR_EDGECAP): rd_mux[WIDTH-1:0] = cap;
      default:                       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.readdata <= '0;
    else if (rd) bus.readdata <= rd_mux;
  end

endmodule

// File: tb/tb_niosiie_pio_in_edge.sv
// Bench for the edge-capturing input PIO.
// Three instances: rising, falling (no irq), any-edge.
`timescale 1ns/1ps
module tb_niosiie_pio_in_edge;

  typedef struct {
    string            name;
    logic [1:0]       addr;
    logic [2:0][31:0] v;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_port = 8'hFF;
  logic [1:0]  address = '0;
  logic        cs = 1'b0;
  logic        rdn = 1'b1;
  logic        wrn = 1'b1;
  logic [31:0] wdata = '0;
  logic [2:0]  irq;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  niosiie_pio_in_edge_if b0 ();
  niosiie_pio_in_edge_if b1 ();
  niosiie_pio_in_edge_if b2 ();

  assign b0.address = address;
  assign b1.address = address;
  assign b2.address = address;
  assign b0.chipselect = cs;
  assign b1.chipselect = cs;
  assign b2.chipselect = cs;
  assign b0.read_n = rdn;
  assign b1.read_n = rdn;
  assign b2.read_n = rdn;
  assign b0.write_n = wrn;
  assign b1.write_n = wrn;
  assign b2.write_n = wrn;
  assign b0.writedata = wdata;
  assign b1.writedata = wdata;
  assign b2.writedata = wdata;

  niosiie_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(0), .IRQ_EN(1)) u0 (
    .clk(clk), .reset_n(reset_n), .bus(b0.slave),
    .in_port(in_port), .irq(irq[0]));
  niosiie_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(1), .IRQ_EN(0)) u1 (
    .clk(clk), .reset_n(reset_n), .bus(b1.slave),
    .in_port(in_port), .irq(irq[1]));
  niosiie_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(2), .IRQ_EN(1)) u2 (
    .clk(clk), .reset_n(reset_n), .bus(b2.slave),
    .in_port(in_port), .irq(irq[2]));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic exp_t mk(string n, logic [1:0] a,
                              logic [31:0] e0, logic [31:0] e1,
                              logic [31:0] e2);
    exp_t x;
    x.name = n;
    x.addr = a;
    x.v[0] = e0;
    x.v[1] = e1;
    x.v[2] = e2;
    return x;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_cycle(input logic c, input logic r, input logic w,
                           input logic [1:0] a, input logic [31:0] d,
                           output logic [2:0][31:0] q);
    @(posedge clk);
    #1;
    cs = c;
    rdn = ~r;
    wrn = ~w;
    address = a;
    wdata = d;
    @(posedge clk);
    #1;
    cs = 1'b0;
    rdn = 1'b1;
    wrn = 1'b1;
    q[0] = b0.readdata;
    q[1] = b1.readdata;
    q[2] = b2.readdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    logic [2:0][31:0] q;
    bus_cycle(1'b1, 1'b0, 1'b1, a, d, q);
  endtask

  task automatic test_reset();
    logic [2:0][31:0] q;
    exp_t e;
    in_port = 8'hFF;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(10);
    exp_q.push_back(mk("rst_edgecap", 2'd3, 0, 0, 0));
    exp_q.push_back(mk("rst_data", 2'd0, 32'hFF, 32'hFF, 32'hFF));
    exp_q.push_back(mk("rst_mask", 2'd2, 0, 0, 0));
    checks++;
    if (irq !== 3'b000) begin
      errors++;
      $display("FAIL rst_irq: got %b expected 000", irq);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      bus_cycle(1'b1, 1'b1, 1'b0, e.addr, 32'h0, q);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (q[k] !== e.v[k]) begin
          errors++;
          $display("FAIL %s u%0d: got %h expected %h", e.name, k, q[k], e.v[k]);
        end
      end
    end
  endtask

  task automatic test_rising();
    logic [2:0][31:0] q;
    exp_t e;
    in_port = 8'h00;
    tick(6);
    bus_write(2'd3, 32'hFF);
    in_port = 8'h05;
    tick(4);
    exp_q.push_back(mk("rise_cap", 2'd3, 32'h05, 32'h00, 32'h05));
    e = exp_q.pop_front();
    bus_cycle(1'b1, 1'b1, 1'b0, e.addr, 32'h0, q);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (q[k] !== e.v[k]) begin
        errors++;
        $display("FAIL %s u%0d: got %h expected %h", e.name, k, q[k], e.v[k]);
      end
    end
    bus_write(2'd2, 32'h04);
    tick(1);
    checks++;
    if (irq !== 3'b101) begin
      errors++;
      $display("FAIL rise_irq_set: got %b expected 101", irq);
    end
    bus_write(2'd3, 32'h04);
    tick(1);
    checks++;
    if (irq !== 3'b000) begin
      errors++;
      $display("FAIL rise_irq_clr: got %b expected 000", irq);
    end
    exp_q.push_back(mk("rise_w1c", 2'd3, 32'h01, 32'h00, 32'h01));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      bus_cycle(1'b1, 1'b1, 1'b0, e.addr, 32'h0, q);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (q[k] !== e.v[k]) begin
          errors++;
          $display("FAIL %s u%0d: got %h expected %h", e.name, k, q[k], e.v[k]);
        end
      end
    end
  endtask

  task automatic test_collision();
    logic [2:0][31:0] q;
    exp_t e;
    in_port = 8'h04;
    tick(5);
    bus_write(2'd3, 32'hFF);
    in_port = 8'h05;
    tick(1);
    // bit0 event is sampled on the same edge as this clear
    bus_write(2'd3, 32'h01);
    exp_q.push_back(mk("collide_cap", 2'd3, 32'h01, 32'h00, 32'h01));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      bus_cycle(1'b1, 1'b1, 1'b0, e.addr, 32'h0, q);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (q[k] !== e.v[k]) begin
          errors++;
          $display("FAIL %s u%0d: got %h expected %h", e.name, k, q[k], e.v[k]);
        end
      end
    end
  endtask

  task automatic test_falling();
    logic [2:0][31:0] q;
    exp_t e;
    bus_write(2'd3, 32'hFF);
    in_port = 8'h0D;
    tick(3);
    in_port = 8'h05;
    tick(5);
    exp_q.push_back(mk("pulse_cap", 2'd3, 32'h08, 32'h08, 32'h08));
    exp_q.push_back(mk("pulse_reread", 2'd3, 32'h08, 32'h08, 32'h08));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      bus_cycle(1'b1, 1'b1, 1'b0, e.addr, 32'h0, q);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (q[k] !== e.v[k]) begin
          errors++;
          $display("FAIL %s u%0d: got %h expected %h", e.name, k, q[k], e.v[k]);
        end
      end
    end
    bus_write(2'd2, 32'hFF);
    tick(1);
    checks++;
    if (irq !== 3'b101) begin
      errors++;
      $display("FAIL pulse_irq: got %b expected 101", irq);
    end
    exp_q.push_back(mk("mask_ff", 2'd2, 32'hFF, 32'h00, 32'hFF));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      bus_cycle(1'b1, 1'b1, 1'b0, e.addr, 32'h0, q);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (q[k] !== e.v[k]) begin
          errors++;
          $display("FAIL %s u%0d: got %h expected %h", e.name, k, q[k], e.v[k]);
        end
      end
    end
  endtask

  task automatic test_read_latency();
    logic [2:0][31:0] q;
    exp_t e;
    bus_write(2'd2, 32'hA5);
    exp_q.push_back(mk("rsvd", 2'd1, 0, 0, 0));
    exp_q.push_back(mk("mask_a5", 2'd2, 32'hA5, 32'h00, 32'hA5));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      bus_cycle(1'b1, 1'b1, 1'b0, e.addr, 32'h0, q);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (q[k] !== e.v[k]) begin
          errors++;
          $display("FAIL %s u%0d: got %h expected %h", e.name, k, q[k], e.v[k]);
        end
      end
    end
    tick(2);
    checks++;
    if (b0.readdata !== 32'hA5) begin
      errors++;
      $display("FAIL rd_hold: got %h expected 000000a5", b0.readdata);
    end
    bus_write(2'd0, 32'hFF);
    bus_cycle(1'b0, 1'b0, 1'b1, 2'd2, 32'h00, q);
    exp_q.push_back(mk("data_ro", 2'd0, 32'h05, 32'h05, 32'h05));
    exp_q.push_back(mk("nocs_wr", 2'd2, 32'hA5, 32'h00, 32'hA5));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      bus_cycle(1'b1, 1'b1, 1'b0, e.addr, 32'h0, q);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (q[k] !== e.v[k]) begin
          errors++;
          $display("FAIL %s u%0d: got %h expected %h", e.name, k, q[k], e.v[k]);
        end
      end
    end
    exp_q.push_back(mk("rw_old", 2'd2, 32'hA5, 32'h00, 32'hA5));
    e = exp_q.pop_front();
    bus_cycle(1'b1, 1'b1, 1'b1, e.addr, 32'h3C, q);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (q[k] !== e.v[k]) begin
        errors++;
        $display("FAIL %s u%0d: got %h expected %h", e.name, k, q[k], e.v[k]);
      end
    end
    exp_q.push_back(mk("rw_new", 2'd2, 32'h3C, 32'h00, 32'h3C));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      bus_cycle(1'b1, 1'b1, 1'b0, e.addr, 32'h0, q);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (q[k] !== e.v[k]) begin
          errors++;
          $display("FAIL %s u%0d: got %h expected %h", e.name, k, q[k], e.v[k]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [2:0][31:0] q;
    exp_t e;
    in_port = 8'h00;
    tick(6);
    bus_write(2'd3, 32'hFF);
    in_port = 8'h03;
    tick(5);
    bus_write(2'd2, 32'hFF);
    tick(1);
    checks++;
    if (irq[0] !== 1'b1) begin
      errors++;
      $display("FAIL mrst_irq_pre: got %b expected 1", irq[0]);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (irq !== 3'b000 || b0.readdata !== 32'h0) begin
      errors++;
      $display("FAIL mrst_async: got irq %b rd %h expected 000/0", irq, b0.readdata);
    end
    tick(1);
    reset_n = 1'b1;
    tick(4);
    exp_q.push_back(mk("mrst_cap", 2'd3, 0, 0, 0));
    exp_q.push_back(mk("mrst_mask", 2'd2, 0, 0, 0));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      bus_cycle(1'b1, 1'b1, 1'b0, e.addr, 32'h0, q);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (q[k] !== e.v[k]) begin
          errors++;
          $display("FAIL %s u%0d: got %h expected %h", e.name, k, q[k], e.v[k]);
        end
      end
    end
    checks++;
    if (irq !== 3'b000) begin
      errors++;
      $display("FAIL mrst_irq_post: got %b expected 000", irq);
    end
    in_port = 8'h07;
    tick(4);
    exp_q.push_back(mk("mrst_recap", 2'd3, 32'h04, 32'h00, 32'h04));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      bus_cycle(1'b1, 1'b1, 1'b0, e.addr, 32'h0, q);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (q[k] !== e.v[k]) begin
          errors++;
          $display("FAIL %s u%0d: got %h expected %h", e.name, k, q[k], e.v[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rising();
    test_collision();
    test_falling();
    test_read_latency();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
